sfm_out_stage: RTL and testbench

Output stage of the softmax accelerator, placed between the datapath result port and the streamer's output stream. It converts lane-level results and per-lane strobes into a full-width beat with byte strobes, enforcing the programmed job length. It buffers up to two beats for backpressure decoupling. It reports job completion and protocol errors to the controller.

---
 rtl/sfm_pkg.sv | 29 ++
 rtl/sfm_out_stage_if.sv | 27 ++
 rtl/sfm_out_fifo.sv | 70 +++++++
 rtl/sfm_out_stage.sv | 142 ++++++++++++++
 tb/tb_sfm_out_stage.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sfm_pkg.sv
// Softmax output stage shared types.
// Holds the FSM encoding, the beat geometry and the strobe expansion.
package sfm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } out_stage_state_e;

  localparam int SFM_RSVD_BITS  = 32;
  localparam int SFM_W          = 16;
  localparam int SFM_DATA_WIDTH = 128;
  localparam int SFM_CNT_WIDTH  = 32;
  localparam int SFM_VECT       =
    (SFM_DATA_WIDTH - SFM_RSVD_BITS) / SFM_W;
  localparam int SFM_STRB_W     = SFM_DATA_WIDTH / 8;

  function automatic logic [SFM_STRB_W-1:0]
    lane_strb_to_byte_strb(input logic [SFM_VECT-1:0] mask);
    logic [SFM_STRB_W-1:0] b;
    b = '0;
    for (int i = 0; i < SFM_VECT; i++) begin
      b[i*(SFM_W/8) +: SFM_W/8] = {(SFM_W/8){mask[i]}};
    end
    return b;
  endfunction

endpackage

// File: rtl/sfm_out_stage_if.sv
// Valid/ready stream bundle with data and strobes.
// Used for both the lane-level input and the beat-level output.
interface sfm_out_stage_if #(
  parameter int DW = 128,
  parameter int SW = 16
) ();

  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic [SW-1:0] strb;

  modport master (
    output valid,
    output data,
    output strb,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  strb,
    output ready
  );

endinterface

// File: rtl/sfm_out_fifo.sv
// Two-entry register FIFO; the head entry drives the outputs
// directly so nothing combinational reaches the consumer.
module sfm_out_fifo #(
  parameter int DW = 128,
  parameter int SW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  input  logic [SW-1:0] strb_i,
  output logic [DW-1:0] data_o,
  output logic [SW-1:0] strb_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          single_o
);

  logic [1:0]    cnt_q;
  logic [DW-1:0] hd_data_q;
  logic [SW-1:0] hd_strb_q;
  logic [DW-1:0] tl_data_q;
  logic [SW-1:0] tl_strb_q;
  logic          do_push;
  logic          do_pop;

  assign full_o   = (cnt_q == 2'd2);
  assign empty_o  = (cnt_q == 2'd0);
  assign single_o = (cnt_q == 2'd1);
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign data_o   = hd_data_q;
  assign strb_o   = hd_strb_q;

  // Shift-style storage: head is always the oldest entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= 2'd0;
      hd_data_q <= '0;
      hd_strb_q <= '0;
      tl_data_q <= '0;
      tl_strb_q <= '0;
    end else if (clear_i) begin
      cnt_q     <= 2'd0;
      hd_data_q <= '0;
      hd_strb_q <= '0;
      tl_data_q <= '0;
      tl_strb_q <= '0;
    end else if (do_push && do_pop) begin
      hd_data_q <= data_i;
      hd_strb_q <= strb_i;
    end else if (do_pop) begin
      hd_data_q <= tl_data_q;
      hd_strb_q <= tl_strb_q;
      cnt_q     <= cnt_q - 2'd1;
    end else if (do_push) begin
      if (empty_o) begin
        hd_data_q <= data_i;
        hd_strb_q <= strb_i;
      end else begin
        tl_data_q <= data_i;
        tl_strb_q <= strb_i;
      end
      cnt_q <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/sfm_out_stage.sv
// Softmax output stage: lane results to byte-strobed beats,
// job-length enforcement, completion and error reporting.
module sfm_out_stage
  import sfm_pkg::*;
#(
  parameter int DATA_WIDTH = SFM_DATA_WIDTH,
  parameter int CNT_WIDTH  = SFM_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  sfm_out_stage_if.slave       in_if,
  sfm_out_stage_if.master      out_if,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int VECT = (DATA_WIDTH - SFM_RSVD_BITS) / SFM_W;
  localparam int SW   = DATA_WIDTH / 8;

  out_stage_state_e     state_q, state_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;

  logic [CNT_WIDTH-1:0] lane_cnt;
  logic [CNT_WIDTH-1:0] take;
  logic [VECT-1:0]      lane_mask;
  logic                 contig;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_single;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [SW-1:0]        beat_strb;

  assign in_if.ready  = (state_q == RUN) && !fifo_full;
  assign out_if.valid = !fifo_empty;
  assign push = in_if.valid && in_if.ready;
  assign pop  = out_if.valid && out_if.ready;

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign err_o  = err_q;

  // A valid strobe is a run of ones starting at lane 0.
  assign contig =
    ((in_if.strb & (in_if.strb + VECT'(1))) == '0);

  // Count active lanes and mask off those past the job end.
  always_comb begin
    lane_cnt  = '0;
    lane_mask = '0;
    for (int i = 0; i < VECT; i++) begin
      lane_cnt = lane_cnt + CNT_WIDTH'(in_if.strb[i]);
      lane_mask[i] = in_if.strb[i] && (CNT_WIDTH'(i) < rem_q);
    end
    take = (lane_cnt > rem_q) ? rem_q : lane_cnt;
  end

  assign beat_data = {{SFM_RSVD_BITS{1'b0}}, in_if.data};
  assign beat_strb = lane_strb_to_byte_strb(lane_mask);

  sfm_out_fifo #(
    .DW (DATA_WIDTH),
    .SW (SW)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (clear_i),
    .push_i   (push),
    .pop_i    (pop),
    .data_i   (beat_data),
    .strb_i   (beat_strb),
    .data_o   (out_if.data),
    .strb_o   (out_if.strb),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .single_o (fifo_single)
  );

  // Next state, remaining count, error and done pulse.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      rem_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            err_d = 1'b0;
            if (len_i == '0) begin
              done_d = 1'b1;
            end else begin
              rem_d   = len_i;
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (push) begin
            rem_d = rem_q - take;
            if (lane_cnt > rem_q || !contig) err_d = 1'b1;
            if (rem_q == take) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty || (fifo_single && pop)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rem_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_sfm_out_stage.sv
// Bench for sfm_out_stage: behavioural queue model checked
// every cycle, directed scenarios plus randomized jobs.
module tb_sfm_out_stage;
  import sfm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        start;
  logic [31:0] len;
  logic        rdy_i;
  logic        busy, done, err;
  bit          rnd_bp = 1'b0;

  sfm_out_stage_if #(.DW(96),  .SW(6))  in_if ();
  sfm_out_stage_if #(.DW(128), .SW(16)) out_if ();

  assign out_if.ready = rdy_i;

  always #5 clk = ~clk;

  sfm_out_stage dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
    .start_i (start),
    .len_i   (len),
    .in_if   (in_if),
    .out_if  (out_if),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err)
  );

  int checks = 0;
  int passed = 0;

  int           m_state;
  longint       m_rem;
  logic         m_err, m_done;
  logic [127:0] q_data[$];
  logic [15:0]  q_strb[$];

  logic [15:0] pop_log[$];
  int          done_cnt = 0;
  int          busy_hi = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h",
                  nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Per-cycle compare against the model, then advance the model
  // with the inputs that will be sampled at the next edge.
  always @(negedge clk) begin : cmp
    bit           pop, push, nd;
    int           n0, cnt, hi;
    logic [15:0]  bs;
    if (!rst_n) begin
      m_state = 0; m_rem = 0; m_err = 0; m_done = 0;
      q_data.delete(); q_strb.delete();
      chk("rst_valid", out_if.valid, 0);
      chk("rst_ready", in_if.ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
    end else begin
      chk("valid", out_if.valid, q_data.size() > 0);
      if (q_data.size() > 0) begin
        chk("data", out_if.data, q_data[0]);
        chk("strb", out_if.strb, q_strb[0]);
      end
      chk("ready", in_if.ready,
          m_state == 1 && q_data.size() < 2);
      chk("busy", busy, m_state != 0);
      chk("done", done, m_done);
      chk("err", err, m_err);
      if (out_if.valid && rdy_i) pop_log.push_back(out_if.strb);
      if (done) done_cnt++;
      if (busy) busy_hi++;
      if (clear) begin
        q_data.delete(); q_strb.delete();
        m_state = 0; m_err = 0; m_done = 0; m_rem = 0;
      end else begin
        n0 = q_data.size();
        pop = n0 > 0 && rdy_i;
        push = m_state == 1 && n0 < 2 && in_if.valid;
        nd = 0;
        if (pop) begin
          void'(q_data.pop_front());
          void'(q_strb.pop_front());
        end
        case (m_state)
          0: if (start) begin
            m_err = 0;
            if (len == 0) nd = 1;
            else begin m_rem = len; m_state = 1; end
          end
          1: if (push) begin
            cnt = 0; hi = -1; bs = '0;
            for (int i = 0; i < 6; i++) begin
              if (in_if.strb[i]) begin cnt++; hi = i; end
              if (in_if.strb[i] && i < m_rem) bs[2*i +: 2] = 2'b11;
            end
            if (cnt > m_rem || cnt != hi + 1) m_err = 1;
            q_data.push_back({32'b0, in_if.data});
            q_strb.push_back(bs);
            m_rem = m_rem - ((cnt > m_rem) ? m_rem : cnt);
            if (m_rem == 0) m_state = 2;
          end
          2: if (n0 == 0 || (n0 == 1 && pop)) begin
            nd = 1; m_state = 0;
          end
          default: m_state = 0;
        endcase
        m_done = nd;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_bp) rdy_i = ($urandom % 4) != 0;
    end
  end

  task automatic do_start(input logic [31:0] l);
    start = 1'b1;
    len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [5:0] s);
    int   n;
    logic acc;
    in_if.valid = 1'b1;
    in_if.strb = s;
    in_if.data = {$urandom, $urandom, $urandom};
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      acc = in_if.ready;
      tick();
      n++;
    end
    if (!acc) begin
      checks++;
      $display("FAIL send_timeout actual=stalled required=accept");
    end
    in_if.valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_state != 0 || busy) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
    tick();
  endtask

  task automatic reset_log();
    pop_log.delete();
    done_cnt = 0;
    busy_hi = 0;
  endtask

  initial begin
    logic [5:0] s;
    int         n;
    rst_n = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    len = '0;
    rdy_i = 1'b0;
    in_if.valid = 1'b0;
    in_if.strb = '0;
    in_if.data = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // basic job
    reset_log();
    rdy_i = 1'b1;
    do_start(12);
    send(6'h3F);
    send(6'h3F);
    wait_idle();
    chk("basic_n", pop_log.size(), 2);
    chk("basic_s0", pop_log[0], 16'h0FFF);
    chk("basic_s1", pop_log[1], 16'h0FFF);
    chk("basic_done", done_cnt, 1);
    chk("basic_err", err, 0);

    // tail truncation
    reset_log();
    do_start(8);
    send(6'h3F);
    send(6'h3F);
    wait_idle();
    chk("tail_s0", pop_log[0], 16'h0FFF);
    chk("tail_s1", pop_log[1], 16'h000F);
    chk("tail_err", err, 1);

    // backpressure
    reset_log();
    rdy_i = 1'b0;
    do_start(30);
    fork
      begin
        repeat (5) send(6'h3F);
      end
      begin
        repeat (5) tick();
        chk("bp_ready", in_if.ready, 0);
        chk("bp_valid", out_if.valid, 1);
        rdy_i = 1'b1;
      end
    join
    wait_idle();
    chk("bp_n", pop_log.size(), 5);
    chk("bp_done", done_cnt, 1);

    // non-contiguous strobe, then flush with 2 beats buffered
    reset_log();
    do_start(60);
    send(6'b000101);
    tick();
    tick();
    chk("nc_strb", pop_log[0], 16'h0033);
    chk("nc_err", err, 1);
    rdy_i = 1'b0;
    send(6'h3F);
    send(6'h3F);
    chk("fl_full", in_if.ready, 0);
    done_cnt = 0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("fl_valid", out_if.valid, 0);
    chk("fl_busy", busy, 0);
    chk("fl_err", err, 0);
    repeat (4) tick();
    chk("fl_done", done_cnt, 0);

    // zero length
    reset_log();
    rdy_i = 1'b1;
    do_start(0);
    repeat (3) tick();
    chk("z_done", done_cnt, 1);
    chk("z_busy", busy_hi, 0);

    // start during a job is ignored
    reset_log();
    do_start(12);
    send(6'h3F);
    do_start(100);
    send(6'h3F);
    wait_idle();
    chk("sr_n", pop_log.size(), 2);
    chk("sr_s1", pop_log[1], 16'h0FFF);
    chk("sr_done", done_cnt, 1);

    // asynchronous reset mid-job
    rdy_i = 1'b0;
    do_start(30);
    send(6'h3F);
    send(6'h3F);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_if.valid, 0);
    chk("ar_ready", in_if.ready, 0);
    chk("ar_data", out_if.data, 0);
    chk("ar_strb", out_if.strb, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_err", err, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // randomized jobs
    rnd_bp = 1'b1;
    repeat (40) begin
      do_start($urandom_range(0, 40));
      n = 0;
      while (m_state == 1 && n < 400) begin
        case ($urandom % 4)
          0: s = 6'h3F;
          1: s = 6'h3F >> ($urandom % 7);
          2: s = 6'($urandom);
          default: s = 6'h00;
        endcase
        in_if.valid = ($urandom % 3) != 0;
        in_if.strb = s;
        in_if.data = {$urandom, $urandom, $urandom};
        start = ($urandom % 25) == 0;
        len = $urandom_range(0, 40);
        clear = ($urandom % 60) == 0;
        tick();
        start = 1'b0;
        clear = 1'b0;
        n++;
      end
      in_if.valid = 1'b0;
      wait_idle();
    end
    rnd_bp = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
